// File: rtl/cpu_storebuffer_drain_ctrl_pkg.sv
// Shared definitions for the store-buffer drain controller.
//   SB_STARVE_LIMIT      : default number of stalled-drain cycles before the
//                          drain overrides pending loads.
//   cpu_sb_drain_state_e : drain FSM state encoding.
package cpu_storebuffer_drain_ctrl_pkg;

    localparam int unsigned SB_STARVE_LIMIT = 8;

    typedef enum logic [2:0] {
        DRAIN_IDLE,
        DRAIN_CHECK,
        DRAIN_FILL,
        DRAIN_WRITE,
        DRAIN_POP
    } cpu_sb_drain_state_e;

endpackage

// File: rtl/cpu_storebuffer_drain_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clock  : system clock
//   reset  : synchronous, active-high; forces count to 0
//   clear  : synchronous clear, has priority over inc
//   inc    : increment request; ignored once count reaches LIMIT
//   count  : current value, 0..LIMIT
module cpu_sat_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LIMIT = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LIMIT_VAL = LIMIT[WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != LIMIT_VAL)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_storebuffer_drain_ctrl.sv
// Store-buffer drain controller. Moves the store-buffer head into the
// direct-mapped data cache, sharing the single cache data port with loads:
// tag lookup, line fill on miss, masked word write, then pop.
// Ports:
//   clock, reset                      : clock, synchronous active-high reset
//   sb_empty, sb_full, sb_push        : store-buffer status
//   sb_tag_pop/data_pop/bytes_pop     : store-buffer head entry
//   sb_pop                            : pop head (one-cycle pulse)
//   load_req / load_grant             : load pipeline port arbitration
//   drain_force / drain_done          : fence: drain until empty / finished
//   cache_lookup, cache_hit           : tag lookup, hit valid one cycle later
//   cache_wr_en/addr/wr_data/wr_bytes : masked word write port
//   fill_req / fill_ack               : line fill handshake
module cpu_storebuffer_drain_ctrl
    import cpu_storebuffer_drain_ctrl_pkg::*;
#(
    parameter int unsigned TAG_WIDTH     = 32,
    parameter int unsigned BYTES_IN_DATA = 4,
    parameter int unsigned DATA_WIDTH    = BYTES_IN_DATA * 8,
    parameter int unsigned STARVE_LIMIT  = SB_STARVE_LIMIT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     sb_empty,
    input  logic                     sb_full,
    input  logic                     sb_push,
    input  logic [TAG_WIDTH-1:0]     sb_tag_pop,
    input  logic [DATA_WIDTH-1:0]    sb_data_pop,
    input  logic [BYTES_IN_DATA-1:0] sb_bytes_pop,
    output logic                     sb_pop,
    input  logic                     load_req,
    output logic                     load_grant,
    input  logic                     drain_force,
    output logic                     drain_done,
    output logic                     cache_lookup,
    input  logic                     cache_hit,
    output logic                     cache_wr_en,
    output logic [TAG_WIDTH-1:0]     cache_addr,
    output logic [DATA_WIDTH-1:0]    cache_wr_data,
    output logic [BYTES_IN_DATA-1:0] cache_wr_bytes,
    output logic                     fill_req,
    input  logic                     fill_ack
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = STARVE_LIMIT[CNT_W-1:0];

    cpu_sb_drain_state_e      state;
    logic [TAG_WIDTH-1:0]     snap_tag;
    logic [DATA_WIDTH-1:0]    snap_data;
    logic [BYTES_IN_DATA-1:0] snap_bytes;
    logic [CNT_W-1:0]         starve_cnt;
    logic                     is_idle;
    logic                     drain_start;
    logic                     starve_inc;

    assign is_idle     = (state == DRAIN_IDLE);
    assign drain_start = is_idle && !sb_empty &&
                         (!load_req || sb_full || drain_force || (starve_cnt == STARVE_MAX));
    assign starve_inc  = is_idle && !sb_empty && load_req && !drain_start;

    cpu_sat_counter #(
        .WIDTH (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clock (clock),
        .reset (reset),
        .clear (drain_start || sb_empty),
        .inc   (starve_inc),
        .count (starve_cnt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= DRAIN_IDLE;
            snap_tag   <= '0;
            snap_data  <= '0;
            snap_bytes <= '0;
        end else begin
            case (state)
                DRAIN_IDLE: begin
                    if (drain_start) begin
                        snap_tag   <= sb_tag_pop;
                        snap_data  <= sb_data_pop;
                        snap_bytes <= sb_bytes_pop;
                        state      <= DRAIN_CHECK;
                    end
                end
                DRAIN_CHECK: state <= cache_hit ? DRAIN_WRITE : DRAIN_FILL;
                DRAIN_FILL: begin
                    if (fill_ack) state <= DRAIN_WRITE;
                end
                // A push in the write cycle defers the pop so the buffer never
                // sees push and pop together.
                DRAIN_WRITE: state <= sb_push ? DRAIN_POP : DRAIN_IDLE;
                DRAIN_POP: begin
                    if (!sb_push) state <= DRAIN_IDLE;
                end
                default: state <= DRAIN_IDLE;
            endcase
        end
    end

    always_comb begin
        cache_lookup   = drain_start;
        load_grant     = load_req && is_idle && !drain_start && !drain_force;
        drain_done     = is_idle && sb_empty;
        fill_req       = (state == DRAIN_FILL);
        cache_wr_en    = (state == DRAIN_WRITE);
        sb_pop         = ((state == DRAIN_WRITE) || (state == DRAIN_POP)) && !sb_push;
        // Lookup address comes straight from the head in the start cycle,
        // from the snapshot for the rest of the drain.
        cache_addr     = drain_start ? sb_tag_pop : snap_tag;
        cache_wr_data  = cache_wr_en ? snap_data : '0;
        cache_wr_bytes = cache_wr_en ? snap_bytes : '0;
    end

endmodule

// File: tb/tb_cpu_storebuffer_drain_ctrl.sv
// Directed self-checking bench for cpu_storebuffer_drain_ctrl.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_cpu_storebuffer_drain_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        sb_empty, sb_full, sb_push;
    logic [31:0] sb_tag_pop;
    logic [31:0] sb_data_pop;
    logic [3:0]  sb_bytes_pop;
    logic        sb_pop;
    logic        load_req, load_grant;
    logic        drain_force, drain_done;
    logic        cache_lookup, cache_hit, cache_wr_en;
    logic [31:0] cache_addr, cache_wr_data;
    logic [3:0]  cache_wr_bytes;
    logic        fill_req, fill_ack;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    cpu_storebuffer_drain_ctrl #(
        .TAG_WIDTH     (32),
        .BYTES_IN_DATA (4),
        .DATA_WIDTH    (32),
        .STARVE_LIMIT  (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .sb_empty       (sb_empty),
        .sb_full        (sb_full),
        .sb_push        (sb_push),
        .sb_tag_pop     (sb_tag_pop),
        .sb_data_pop    (sb_data_pop),
        .sb_bytes_pop   (sb_bytes_pop),
        .sb_pop         (sb_pop),
        .load_req       (load_req),
        .load_grant     (load_grant),
        .drain_force    (drain_force),
        .drain_done     (drain_done),
        .cache_lookup   (cache_lookup),
        .cache_hit      (cache_hit),
        .cache_wr_en    (cache_wr_en),
        .cache_addr     (cache_addr),
        .cache_wr_data  (cache_wr_data),
        .cache_wr_bytes (cache_wr_bytes),
        .fill_req       (fill_req),
        .fill_ack       (fill_ack)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; sb_empty = 1'b1; sb_full = 1'b0; sb_push = 1'b0;
        sb_tag_pop = '0; sb_data_pop = '0; sb_bytes_pop = '0;
        load_req = 1'b0; drain_force = 1'b0; cache_hit = 1'b0; fill_ack = 1'b0;

        // Reset state
        cyc(); cyc();
        settle();
        check_eq("rst_sb_pop", sb_pop, 1'b0);
        check_eq("rst_drain_done", drain_done, 1'b1);
        check_eq("rst_wr_en", cache_wr_en, 1'b0);
        check_eq("rst_fill_req", fill_req, 1'b0);
        check_eq("rst_lookup", cache_lookup, 1'b0);
        check_eq("rst_grant_idle", load_grant, 1'b0);
        load_req = 1'b1; settle();
        check_eq("rst_grant_follows", load_grant, 1'b1);
        load_req = 1'b0;
        cyc();
        reset = 1'b0;

        // Hit drain, no loads
        cyc();
        sb_empty = 1'b0; sb_tag_pop = 32'h100; sb_data_pop = 32'hAABBCCDD;
        sb_bytes_pop = 4'b1111; cache_hit = 1'b1; settle();
        check_eq("hit_lookup", cache_lookup, 1'b1);
        check_eq("hit_lookup_addr", cache_addr, 32'h100);
        check_eq("hit_done_busy", drain_done, 1'b0);
        cyc();
        sb_tag_pop = 32'h200; sb_data_pop = 32'h0; settle();
        check_eq("hit_n1_wr_en", cache_wr_en, 1'b0);
        check_eq("hit_n1_pop", sb_pop, 1'b0);
        check_eq("hit_n1_addr_snap", cache_addr, 32'h100);
        cyc(); settle();
        check_eq("hit_n2_wr_en", cache_wr_en, 1'b1);
        check_eq("hit_n2_pop", sb_pop, 1'b1);
        check_eq("hit_n2_data", cache_wr_data, 32'hAABBCCDD);
        check_eq("hit_n2_bytes", cache_wr_bytes, 4'b1111);
        check_eq("hit_n2_addr", cache_addr, 32'h100);
        cyc();
        sb_empty = 1'b1; settle();
        check_eq("hit_n3_wr_en", cache_wr_en, 1'b0);
        check_eq("hit_n3_pop", sb_pop, 1'b0);
        check_eq("hit_n3_done", drain_done, 1'b1);

        // Miss with fill: ack on the fifth fill_req cycle
        cyc();
        sb_empty = 1'b0; sb_tag_pop = 32'h240; sb_data_pop = 32'h11223344;
        sb_bytes_pop = 4'b0101; cache_hit = 1'b0; settle();
        check_eq("miss_lookup", cache_lookup, 1'b1);
        cyc(); settle();
        check_eq("miss_check_fill", fill_req, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 4) fill_ack = 1'b1;
            settle();
            check_eq($sformatf("miss_fill_req_%0d", i), fill_req, 1'b1);
            check_eq($sformatf("miss_fill_wr_%0d", i), cache_wr_en, 1'b0);
            check_eq($sformatf("miss_fill_pop_%0d", i), sb_pop, 1'b0);
        end
        cyc();
        fill_ack = 1'b0; settle();
        check_eq("miss_fill_drop", fill_req, 1'b0);
        check_eq("miss_wr_en", cache_wr_en, 1'b1);
        check_eq("miss_wr_data", cache_wr_data, 32'h11223344);
        check_eq("miss_wr_bytes", cache_wr_bytes, 4'b0101);
        check_eq("miss_wr_addr", cache_addr, 32'h240);
        check_eq("miss_pop", sb_pop, 1'b1);
        cyc();
        sb_empty = 1'b1; settle();
        check_eq("miss_pop_once", sb_pop, 1'b0);
        check_eq("miss_done", drain_done, 1'b1);

        // Starvation: loads win for 8 cycles, drain takes the 9th
        cyc();
        sb_empty = 1'b0; load_req = 1'b1; cache_hit = 1'b1; sb_tag_pop = 32'h300;
        for (int i = 0; i < 8; i++) begin
            settle();
            check_eq($sformatf("starve_grant_%0d", i), load_grant, 1'b1);
            check_eq($sformatf("starve_nolookup_%0d", i), cache_lookup, 1'b0);
            cyc();
        end
        settle();
        check_eq("starve_grant_off", load_grant, 1'b0);
        check_eq("starve_lookup", cache_lookup, 1'b1);
        cyc(); settle();
        check_eq("starve_check_grant", load_grant, 1'b0);
        cyc(); settle();
        check_eq("starve_pop", sb_pop, 1'b1);
        cyc();
        sb_empty = 1'b1; settle();
        check_eq("starve_idle_grant", load_grant, 1'b1);

        // Full override, then push collision in the write cycle
        cyc();
        sb_empty = 1'b0; sb_full = 1'b1; sb_tag_pop = 32'h400;
        sb_data_pop = 32'hCAFEF00D; sb_bytes_pop = 4'b1000; settle();
        check_eq("full_lookup", cache_lookup, 1'b1);
        check_eq("full_grant", load_grant, 1'b0);
        cyc(); cyc();
        sb_push = 1'b1; settle();
        check_eq("push_wr_en", cache_wr_en, 1'b1);
        check_eq("push_wr_data", cache_wr_data, 32'hCAFEF00D);
        check_eq("push_no_pop_w", sb_pop, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(); settle();
            check_eq($sformatf("push_wr_once_%0d", i), cache_wr_en, 1'b0);
            check_eq($sformatf("push_no_pop_%0d", i), sb_pop, 1'b0);
            check_eq($sformatf("push_no_grant_%0d", i), load_grant, 1'b0);
        end
        cyc();
        sb_push = 1'b0; settle();
        check_eq("push_pop", sb_pop, 1'b1);
        check_eq("push_pop_wr_en", cache_wr_en, 1'b0);
        cyc();
        sb_full = 1'b0; sb_empty = 1'b1; load_req = 1'b0; settle();
        check_eq("push_after_pop", sb_pop, 1'b0);
        check_eq("push_done", drain_done, 1'b1);

        // Forced drain: two entries back-to-back despite loads
        cyc();
        drain_force = 1'b1; load_req = 1'b1; sb_empty = 1'b0; sb_tag_pop = 32'h500; settle();
        check_eq("force_lookup0", cache_lookup, 1'b1);
        check_eq("force_grant0", load_grant, 1'b0);
        cyc(); cyc(); settle();
        check_eq("force_pop0", sb_pop, 1'b1);
        cyc();
        sb_tag_pop = 32'h504; settle();
        check_eq("force_lookup1", cache_lookup, 1'b1);
        check_eq("force_addr1", cache_addr, 32'h504);
        check_eq("force_grant1", load_grant, 1'b0);
        cyc(); cyc(); settle();
        check_eq("force_pop1", sb_pop, 1'b1);
        cyc();
        sb_empty = 1'b1; settle();
        check_eq("force_done", drain_done, 1'b1);
        check_eq("force_blocks_load", load_grant, 1'b0);
        drain_force = 1'b0; settle();
        check_eq("force_release_grant", load_grant, 1'b1);

        // Reset during FILL aborts; later fill_ack ignored
        cyc();
        load_req = 1'b0; sb_empty = 1'b0; cache_hit = 1'b0; sb_tag_pop = 32'h600;
        cyc(); cyc(); settle();
        check_eq("rfill_fill_req", fill_req, 1'b1);
        cyc();
        reset = 1'b1; settle();
        check_eq("rfill_pre_pop", sb_pop, 1'b0);
        cyc();
        reset = 1'b0; sb_empty = 1'b1; settle();
        check_eq("rfill_fill_drop", fill_req, 1'b0);
        check_eq("rfill_idle_done", drain_done, 1'b1);
        check_eq("rfill_no_pop", sb_pop, 1'b0);
        cyc();
        fill_ack = 1'b1; settle();
        check_eq("rfill_ack_fill", fill_req, 1'b0);
        check_eq("rfill_ack_wr", cache_wr_en, 1'b0);
        cyc();
        fill_ack = 1'b0; settle();
        check_eq("rfill_late_wr", cache_wr_en, 1'b0);
        check_eq("rfill_late_pop", sb_pop, 1'b0);
        check_eq("rfill_late_done", drain_done, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
